// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: Diff = A - B - Bin, one bit per clock, LSB first,
// through a single full-subtractor cell. Start/busy/done handshake; results hold until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic             last;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor cell on the current LSB of the operand shift registers.
    always_comb begin
        a_bit    = a_sh[0];
        b_bit    = b_sh[0];
        d_bit    = a_bit ^ b_bit ^ br;
        br_next  = (~a_bit & b_bit) | (~a_bit & br) | (b_bit & br);
        res_next = {d_bit, res[WIDTH-1:1]};
        last     = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Diff  <= '0;
            Bout  <= 1'b0;
            Ovf   <= 1'b0;
            Zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != BUSY) begin
                // IDLE and DONE both accept a new operation.
                if (start) begin
                    a_sh  <= A;
                    b_sh  <= B;
                    br    <= Bin;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= BUSY;
                end else begin
                    state <= IDLE;
                end
            end else begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                br   <= br_next;
                res  <= res_next;
                cnt  <= cnt + 1'b1;
                if (last) begin
                    // The last bit processed is the MSB, so a_bit/b_bit/d_bit are the sign bits.
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    Diff  <= res_next;
                    Bout  <= br_next;
                    Ovf   <= (a_bit != b_bit) && (d_bit != a_bit);
                    Zero  <= (res_next == '0);
                end
            end
        end
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, bit-serial ripple-borrow subtractor. Computes A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell.
- Inverse arithmetic companion to the team's ripple-carry adder. Used where area matters more than latency.
- Operands are accepted on a start/busy/done handshake. Results are held stable until the next operation completes.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new subtraction; sampled only when busy=0
- A  input  WIDTH  minuend, captured on accepted start
- B  input  WIDTH  subtrahend, captured on accepted start
- Bin  input  1  borrow-in, captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse when a new result is valid
- Diff  output  WIDTH  difference A − B − Bin (mod 2^WIDTH)
- Bout  output  1  borrow-out (1 when the unsigned A < B + Bin)
- Ovf  output  1  signed (two's complement) overflow
- Zero  output  1  Diff == 0

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE.
  - Synchronous only; takes effect at the next rising edge with rst=1 and has priority over everything else.
  - Reset mid-operation abandons the operation. No done pulse follows, and Diff/Bout/Ovf/Zero return to 0.
- FSM states:
  - IDLE: busy=0, done=0. start=1 → capture A, B, Bin into internal shift registers; borrow register := Bin; bit counter := 0; go to BUSY.
  - BUSY: busy=1. Each edge processes bit i = counter:
    - d_i = a_i ^ b_i ^ br
    - br' = (~a_i & b_i) | (~a_i & br) | (b_i & br)
    - d_i is shifted into an internal result register, MSB-first entry so that after WIDTH shifts bit 0 lands at position 0.
    - When counter = WIDTH−1, the edge processes the last bit, then the FSM goes to DONE and loads the output registers.
  - DONE: done=1 and busy=0 for exactly one cycle.
    - start=1 in this cycle is accepted exactly as in IDLE (next state BUSY). Otherwise → IDLE.
- Latency:
  - start sampled at edge k.
  - busy=1 from after edge k through edge k+WIDTH.
  - done=1 in the cycle after edge k+WIDTH.
  - Back-to-back throughput is one operation per WIDTH+1 cycles.
- Output update:
  - Diff, Bout, Ovf and Zero change only at the edge entering DONE, or at reset.
  - They hold their previous values throughout BUSY and IDLE.
- Flag definitions:
  - Bout = final borrow register value.
  - Ovf = (A[WIDTH−1] != B[WIDTH−1]) && (Diff[WIDTH−1] != A[WIDTH−1]), using the captured A and B.
    - Bin is treated as part of the subtrahend for Diff only.
  - Zero = (Diff == 0).
- Input handling:
  - start while busy=1 is ignored and has no effect on the operation in flight.
  - A, B and Bin may change freely after capture.
- Bit counter width is clog2(WIDTH) or wider; the counter never wraps within an operation.

Test Plan (WIDTH=4):
- Basic subtract: A=7, B=3, Bin=0, start one cycle.
  - busy high 4 cycles, then done 1 cycle.
  - Diff=4, Bout=0, Ovf=0, Zero=0.
- Unsigned borrow: A=3, B=7, Bin=0.
  - Diff=0xC, Bout=1, Ovf=0.
- Borrow-in only: A=0, B=0, Bin=1.
  - Diff=0xF, Bout=1, Zero=0.
- Signed overflow, case 1: A=0x8 (−8), B=0x1, Bin=0.
  - Diff=0x7, Ovf=1, Bout=0.
- Signed overflow, case 2: A=0x7, B=0xF (−1).
  - Diff=0x8, Ovf=1, Bout=1.
- Zero result: A=5, B=5, Bin=0.
  - Diff=0, Zero=1, Bout=0.
- Handshake and reset checks:
  - Pulse start again during BUSY with different operands → ignored; first result reported.
  - start held high through DONE → second op accepted and done pulses again 5 cycles later.
  - rst asserted after 2 BUSY cycles → next cycle busy=0, done=0, all outputs 0, and no done pulse follows.
- Exhaustive sweep: all 16×16×2 combinations of A, B, Bin against a reference model for Diff, Bout, Ovf and Zero.
